// File: rtl/fpu_div_pkg.sv
// Shared constants and state encoding for the log-datapath divider.
// Operand format: 26 fraction bits; product format: 52 fraction bits.
package fpu_div_pkg;

    localparam int W        = 32;
    localparam int FRAC_IN  = 52;
    localparam int FRAC_OUT = 26;

    localparam logic [W-1:0] QSAT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: trial-subtract the divisor from R'.
// The compare is W+1 bits wide so the shifted-in MSB is never lost.
module div_restoring_step
    import fpu_div_pkg::*;
(
    input  logic [W:0]   rp,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_new,
    output logic         qbit
);

    logic [W:0] dext;

    assign dext  = {1'b0, divisor};
    assign qbit  = (rp >= dext);
    assign r_new = qbit ? (rp - dext) : rp;

endmodule

// File: rtl/fixed_point_divider_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Undoes a 32x32 fixed-point multiply: 62-bit Y / 32-bit B -> 32-bit Q.
module fixed_point_divider_seq
    import fpu_div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-3:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(W);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  rem;
    logic [W-1:0]  shreg;
    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic [W-1:0]  hi;
    logic [W:0]    rp;
    logic [W:0]    r_new;
    logic          qbit;
    logic          accept;
    logic          exc;
    logic          unused_rmsb;

    assign hi     = {2'b00, dividend[2*W-3:W]};
    assign accept = start && (state != CALC);
    assign exc    = (divisor == '0) || (hi >= divisor);
    assign busy   = (state == CALC);
    assign done   = (state == DONE);

    // R stays below the divisor, so only its low W bits are stored;
    // shreg shifts dividend bits out at the top and quotient bits in below.
    assign rp          = {rem, shreg[W-1]};
    assign unused_rmsb = r_new[W];

    div_restoring_step u_step (
        .rp      (rp),
        .divisor (dvs),
        .r_new   (r_new),
        .qbit    (qbit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = exc ? DONE : CALC;
                else        state_nxt = IDLE;
            end
            CALC: begin
                if (cnt == '0) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch on accept, iterate in CALC, publish on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            rem         <= '0;
            shreg       <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            dvs         <= divisor;
            rem         <= hi;
            shreg       <= dividend[W-1:0];
            cnt         <= CW'(W - 1);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
                quotient    <= QSAT;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else if (hi >= divisor) begin
                quotient  <= QSAT;
                remainder <= '0;
                overflow  <= 1'b1;
            end
        end else if (state == CALC) begin
            rem   <= r_new[W-1:0];
            shreg <= {shreg[W-2:0], qbit};
            cnt   <= cnt - 1'b1;
            if (cnt == '0) begin
                quotient  <= {shreg[W-2:0], qbit};
                remainder <= r_new[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_divider_seq.sv
// Self-checking bench for fixed_point_divider_seq.
// Table vectors, random vectors vs. an arithmetic model, corner sequences.
module tb_fixed_point_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [61:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fixed_point_divider_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [61:0] y;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        bit          ov;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Plain arithmetic reference: Q = floor(Y/B), R = Y mod B, saturate
    // when B is zero or the true quotient needs more than 32 bits.
    task automatic model(input logic [61:0] y, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output bit dz, output bit ov);
        longint unsigned yy, bb, qq;
        yy = 64'(y);
        bb = 64'(b);
        dz = 1'b0;
        ov = 1'b0;
        if (bb == 0) begin
            q  = 32'hFFFF_FFFF;
            r  = 32'h0;
            dz = 1'b1;
        end else begin
            qq = yy / bb;
            if (qq > 64'h0000_0000_FFFF_FFFF) begin
                q  = 32'hFFFF_FFFF;
                r  = 32'h0;
                ov = 1'b1;
            end else begin
                q = qq[31:0];
                r = 32'(yy % bb);
            end
        end
    endtask

    // Issue one request from the current cycle and check the result.
    // With disturb set, start pulses and input changes hit during CALC.
    task automatic run(input logic [61:0] y, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input bit edz, input bit eov, input bit disturb,
                       input string nm);
        int n;
        int elat;
        elat      = (edz || eov) ? 0 : 32;
        dividend  = y;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (disturb) begin
            dividend = {$urandom(), $urandom()};
            divisor  = 32'h0;
        end
        check({nm, "_busy"}, 64'(busy), 64'(elat != 0));
        n = 0;
        while (!done && n < 40) begin
            if (disturb && n >= 2 && n < 6) begin
                start    = 1'b1;
                divisor  = $urandom();
                dividend = {$urandom(), $urandom()};
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check({nm, "_lat"}, 64'(n), 64'(elat));
        check({nm, "_q"}, 64'(quotient), 64'(eq));
        check({nm, "_r"}, 64'(remainder), 64'(er));
        check({nm, "_dz"}, 64'(div_by_zero), 64'(edz));
        check({nm, "_ov"}, 64'(overflow), 64'(eov));
    endtask

    vec_t tbl[$];

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        bit          ov;
        logic [63:0] t;
        int          pulses;

        tbl.push_back('{62'h0020_0000_0000_0000, 32'h0800_0000,
                        32'h0400_0000, 32'h0, 1'b0, 1'b0});
        tbl.push_back('{62'h0030_0000_0000_0000, 32'h0800_0000,
                        32'h0600_0000, 32'h0, 1'b0, 1'b0});
        tbl.push_back('{62'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0});
        tbl.push_back('{62'h3FFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF,
                        32'h4000_0000, 32'h3FFF_FFFF, 1'b0, 1'b0});
        tbl.push_back('{62'h123, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0});
        tbl.push_back('{62'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0});
        tbl.push_back('{62'h0000_0002_0000_0000, 32'd2,
                        32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1});
        tbl.push_back('{62'h0000_0001_FFFF_FFFF, 32'd2,
                        32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0});
        tbl.push_back('{62'h0, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0});

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_r", 64'(remainder), 64'd0);
        check("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors, issued back-to-back in each done cycle
        foreach (tbl[i]) begin
            run(tbl[i].y, tbl[i].b, tbl[i].q, tbl[i].r,
                tbl[i].dz, tbl[i].ov, 1'b0, $sformatf("tbl%0d", i));
        end

        // Start pulses and input changes during CALC must be ignored
        run(62'h0030_0000_0000_0000, 32'h0800_0000, 32'h0600_0000,
            32'h0, 1'b0, 1'b0, 1'b1, "ignore");

        // Reset part-way through CALC aborts with no done pulse
        dividend = 62'h0020_0000_0000_0000;
        divisor  = 32'h0800_0000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_q", 64'(quotient), 64'd0);
        check("abort_r", 64'(remainder), 64'd0);
        check("abort_flags", 64'({div_by_zero, overflow}), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_nodone", 64'(pulses), 64'd0);
        run(62'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0, "after_abort");

        // Random vectors against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            logic [61:0] y;
            logic [31:0] b;
            t = {$urandom(), $urandom()};
            y = t[61:0] >> $urandom_range(0, 40);
            b = $urandom();
            if (i % 4 == 3) b = b >> $urandom_range(0, 31);
            if (i == 11) b = 32'h0;
            model(y, b, q, r, dz, ov);
            run(y, b, q, r, dz, ov, 1'b0, $sformatf("rnd%0d", i));
            if (i % 5 == 4) begin
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
